execute_cc_pipe_reg: RTL and testbench

- Sits directly downstream of the execute-stage ALU units (add/sub/and/xor); consumes the 64-bit result and the 3-bit condition-code vector {ZF,SF,OF} they produce.
- Holds the architectural condition-code register (CC).
- Evaluates the branch/cmov condition (Cnd) against CC.
- Registers the execute results into the E/M pipeline register, with stall and bubble control, feeding the memory stage.

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/cond_eval.sv | 44 ++++
 rtl/execute_cc_pipe_reg.sv | 175 +++++++++++++++++
 tb/tb_execute_cc_pipe_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
//   Constants shared by the Y86-64 execute stage and its helpers:
//   - instruction codes used by the execute/memory boundary
//   - condition function codes (ifun) for cmovXX / jXX
//   - pipeline status codes
//   - the "no register" ID
//   - bit positions of the condition-code flags inside the 3-bit CC vector
// -----------------------------------------------------------------------------
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;

  // Condition function codes
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // Pipeline status codes
  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  // Register ID meaning "no destination"
  localparam logic [3:0] RNONE = 4'hF;

  // Flag positions inside the CC vector {ZF,SF,OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Reset / power-up contents of the CC register: ZF set, SF and OF clear
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
//   Purely combinational evaluation of a Y86-64 branch/cmov condition against
//   a condition-code vector. No icode qualification is done here; the caller
//   decides whether the result is meaningful.
//
// Ports:
//   cc_i   in  3  condition codes {ZF,SF,OF}
//   ifun_i in  4  condition function code (0 always .. 6 g, 7-15 never)
//   cnd_o  out 1  condition holds
// -----------------------------------------------------------------------------
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc_i,
  input  logic [3:0] ifun_i,
  output logic       cnd_o
);

  logic zf;
  logic sf;
  logic of;
  logic lt;  // signed "less than" after a subtraction: SF xor OF

  assign zf = cc_i[CC_ZF];
  assign sf = cc_i[CC_SF];
  assign of = cc_i[CC_OF];
  assign lt = sf ^ of;

  always_comb begin
    cnd_o = 1'b0;
    case (ifun_i)
      C_ALWAYS: cnd_o = 1'b1;
      C_LE:     cnd_o = lt | zf;
      C_L:      cnd_o = lt;
      C_E:      cnd_o = zf;
      C_NE:     cnd_o = ~zf;
      C_GE:     cnd_o = ~lt;
      C_G:      cnd_o = ~lt & ~zf;
      default:  cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_pipe_reg.sv
// -----------------------------------------------------------------------------
// execute_cc_pipe_reg
//   Back end of the Y86-64 execute stage: holds the architectural condition
//   code register, evaluates the cmov/jump condition against it, and registers
//   the execute results into the E/M pipeline register with stall/bubble
//   control.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   e_valid               execute stage holds a real instruction
//   e_icode, e_ifun       instruction / function code
//   e_valE, e_valA        ALU result / pass-through operand (W bits)
//   e_dstE, e_dstM        destination register IDs
//   e_stat                instruction status (AOK/HLT/ADR/INS)
//   alu_co                ALU flags {ZF,SF,OF}
//   m_stat_bad,W_stat_bad a later stage holds an exception
//   M_stall, M_bubble     E/M register hold / NOP injection (stall wins)
//   cc                    current CC register
//   e_cnd                 combinational condition for this instruction
//   M_*                   registered E/M pipeline fields
// -----------------------------------------------------------------------------
module execute_cc_pipe_reg #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = y86_pkg::RNONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] e_valE,
  input  logic [W-1:0] e_valA,
  input  logic [3:0]   e_dstE,
  input  logic [3:0]   e_dstM,
  input  logic [1:0]   e_stat,
  input  logic [2:0]   alu_co,
  input  logic         m_stat_bad,
  input  logic         W_stat_bad,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [2:0]   cc,
  output logic         e_cnd,
  output logic         M_valid,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic [1:0]   M_stat
);

  import y86_pkg::*;

  // ---------------------------------------------------------------------------
  // Condition evaluation against the CC value held before this cycle's update
  // ---------------------------------------------------------------------------
  logic [2:0] cc_q;
  logic [2:0] cc_d;
  logic       cnd_raw;
  logic       is_cond_insn;

  cond_eval u_cond_eval (
    .cc_i   (cc_q),
    .ifun_i (e_ifun),
    .cnd_o  (cnd_raw)
  );

  assign is_cond_insn = (e_icode == I_CMOV) || (e_icode == I_JXX);
  assign e_cnd        = is_cond_insn & cnd_raw;

  // ---------------------------------------------------------------------------
  // CC update: only a clean OPq that will actually advance may write the flags.
  // A stalled OPq will be re-presented, so it must not write yet; an exception
  // downstream means this instruction is architecturally squashed.
  // ---------------------------------------------------------------------------
  logic set_cc;

  assign set_cc = e_valid & (e_icode == I_OPQ) & ~m_stat_bad & ~W_stat_bad
                & ~M_stall & (e_stat == STAT_AOK);

  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d = alu_co;
    end
  end

  // A cmov whose condition fails must not write its destination.
  logic [3:0] dste_eff;

  assign dste_eff = ((e_icode == I_CMOV) && !e_cnd) ? RNONE : e_dstE;

  // ---------------------------------------------------------------------------
  // E/M pipeline register, priority stall > bubble > load
  // ---------------------------------------------------------------------------
  logic         m_valid_q, m_valid_d;
  logic [3:0]   m_icode_q, m_icode_d;
  logic         m_cnd_q,   m_cnd_d;
  logic [W-1:0] m_vale_q,  m_vale_d;
  logic [W-1:0] m_vala_q,  m_vala_d;
  logic [3:0]   m_dste_q,  m_dste_d;
  logic [3:0]   m_dstm_q,  m_dstm_d;
  logic [1:0]   m_stat_q,  m_stat_d;

  always_comb begin
    // hold by default (covers the stall case)
    m_valid_d = m_valid_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    m_stat_d  = m_stat_q;

    if (!M_stall) begin
      if (M_bubble || !e_valid) begin
        // NOP bubble: same contents as after reset
        m_valid_d = 1'b0;
        m_icode_d = I_NOP;
        m_cnd_d   = 1'b0;
        m_vale_d  = '0;
        m_vala_d  = '0;
        m_dste_d  = RNONE;
        m_dstm_d  = RNONE;
        m_stat_d  = STAT_AOK;
      end else begin
        m_valid_d = 1'b1;
        m_icode_d = e_icode;
        m_cnd_d   = e_cnd;
        m_vale_d  = e_valE;
        m_vala_d  = e_valA;
        m_dste_d  = dste_eff;
        m_dstm_d  = e_dstM;
        m_stat_d  = e_stat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q      <= CC_RESET;
      m_valid_q <= 1'b0;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
      m_stat_q  <= STAT_AOK;
    end else begin
      cc_q      <= cc_d;
      m_valid_q <= m_valid_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
      m_stat_q  <= m_stat_d;
    end
  end

  assign cc      = cc_q;
  assign M_valid = m_valid_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;
  assign M_stat  = m_stat_q;

endmodule

// File: tb/tb_execute_cc_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_execute_cc_pipe_reg
//   Self-checking bench for execute_cc_pipe_reg: a hand-written async reset
//   sequence followed by a table of per-cycle vectors whose expected E/M
//   contents flow through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_execute_cc_pipe_reg;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         e_valid;
  logic [3:0]   e_icode;
  logic [3:0]   e_ifun;
  logic [W-1:0] e_valE;
  logic [W-1:0] e_valA;
  logic [3:0]   e_dstE;
  logic [3:0]   e_dstM;
  logic [1:0]   e_stat;
  logic [2:0]   alu_co;
  logic         m_stat_bad;
  logic         W_stat_bad;
  logic         M_stall;
  logic         M_bubble;
  logic [2:0]   cc;
  logic         e_cnd;
  logic         M_valid;
  logic [3:0]   M_icode;
  logic         M_cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;
  logic [1:0]   M_stat;

  execute_cc_pipe_reg #(.W(W), .RNONE(4'hF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .e_valid    (e_valid),
    .e_icode    (e_icode),
    .e_ifun     (e_ifun),
    .e_valE     (e_valE),
    .e_valA     (e_valA),
    .e_dstE     (e_dstE),
    .e_dstM     (e_dstM),
    .e_stat     (e_stat),
    .alu_co     (alu_co),
    .m_stat_bad (m_stat_bad),
    .W_stat_bad (W_stat_bad),
    .M_stall    (M_stall),
    .M_bubble   (M_bubble),
    .cc         (cc),
    .e_cnd      (e_cnd),
    .M_valid    (M_valid),
    .M_icode    (M_icode),
    .M_cnd      (M_cnd),
    .M_valE     (M_valE),
    .M_valA     (M_valA),
    .M_dstE     (M_dstE),
    .M_dstM     (M_dstM),
    .M_stat     (M_stat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic         valid;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [63:0]  valE;
    logic [63:0]  valA;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [1:0]   stat;
    logic [2:0]   alu;
    logic         mbad;
    logic         wbad;
    logic         stall;
    logic         bubble;
    logic         x_cnd;   // expected combinational e_cnd before the edge
  } stim_t;

  typedef struct packed {
    logic [2:0]   cc;
    logic         valid;
    logic [3:0]   icode;
    logic         cnd;
    logic [63:0]  valE;
    logic [63:0]  valA;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [1:0]   stat;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];
  exp_t sb_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic v, input logic [3:0] ic, input logic [3:0] fn,
    input logic [63:0] ve, input logic [63:0] va,
    input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st,
    input logic [2:0] al, input logic mb, input logic wb, input logic sl, input logic bu,
    input logic xc, input logic [2:0] ecc,
    input logic ev, input logic [3:0] eic, input logic ecn,
    input logic [63:0] eve, input logic [63:0] eva,
    input logic [3:0] ede, input logic [3:0] edm, input logic [1:0] est);
    vec_t r;
    r.s = '{v, ic, fn, ve, va, de, dm, st, al, mb, wb, sl, bu, xc};
    r.e = '{ecc, ev, eic, ecn, eve, eva, ede, edm, est};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    e_valid = 0; e_icode = 4'h1; e_ifun = 0; e_valE = 0; e_valA = 0;
    e_dstE = 4'hF; e_dstM = 4'hF; e_stat = 0; alu_co = 0;
    m_stat_bad = 0; W_stat_bad = 0; M_stall = 0; M_bubble = 0;
  endtask

  task automatic apply(input stim_t s);
    e_valid = s.valid; e_icode = s.icode; e_ifun = s.ifun;
    e_valE = s.valE; e_valA = s.valA; e_dstE = s.dstE; e_dstM = s.dstM;
    e_stat = s.stat; alu_co = s.alu; m_stat_bad = s.mbad; W_stat_bad = s.wbad;
    M_stall = s.stall; M_bubble = s.bubble;
  endtask

  task automatic check_out(input int idx, input exp_t e);
    chk($sformatf("v%0d cc", idx),     {61'd0, cc},      {61'd0, e.cc});
    chk($sformatf("v%0d M_valid", idx), {63'd0, M_valid}, {63'd0, e.valid});
    chk($sformatf("v%0d M_icode", idx), {60'd0, M_icode}, {60'd0, e.icode});
    chk($sformatf("v%0d M_cnd", idx),  {63'd0, M_cnd},   {63'd0, e.cnd});
    chk($sformatf("v%0d M_valE", idx), M_valE,           e.valE);
    chk($sformatf("v%0d M_valA", idx), M_valA,           e.valA);
    chk($sformatf("v%0d M_dstE", idx), {60'd0, M_dstE},  {60'd0, e.dstE});
    chk($sformatf("v%0d M_dstM", idx), {60'd0, M_dstM},  {60'd0, e.dstM});
    chk($sformatf("v%0d M_stat", idx), {62'd0, M_stat},  {62'd0, e.stat});
  endtask

  initial begin
    exp_t e;
    //            v ic fn valE                      valA     dE    dM    st al      mb wb sl bu xc  cc      ev ic cn valE                      valA     dE    dM    st
    vecs[0]  = mk(0, 6, 0, 64'h0,                   64'h0,   4'hF, 4'hF, 0, 3'b001, 0, 0, 0, 0, 0, 3'b100, 0, 1, 0, 64'h0,                   64'h0,   4'hF, 4'hF, 0);
    vecs[1]  = mk(1, 6, 3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1234,4'h2, 4'hF, 0, 3'b010, 0, 0, 0, 0, 0, 3'b010, 1, 6, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1234,4'h2, 4'hF, 0);
    vecs[2]  = mk(1, 7, 2, 64'h100,                 64'h0,   4'hF, 4'hF, 0, 3'b111, 0, 0, 0, 0, 1, 3'b010, 1, 7, 1, 64'h100,                 64'h0,   4'hF, 4'hF, 0);
    vecs[3]  = mk(1, 7, 3, 64'h200,                 64'h0,   4'hF, 4'hF, 0, 3'b111, 0, 0, 0, 0, 0, 3'b010, 1, 7, 0, 64'h200,                 64'h0,   4'hF, 4'hF, 0);
    vecs[4]  = mk(1, 6, 0, 64'h5,                   64'h6,   4'h4, 4'hF, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 6, 0, 64'h5,                   64'h6,   4'h4, 4'hF, 0);
    vecs[5]  = mk(1, 2, 3, 64'h7,                   64'h7,   4'h3, 4'hF, 0, 3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 2, 0, 64'h7,                   64'h7,   4'hF, 4'hF, 0);
    vecs[6]  = mk(1, 6, 0, 64'h0,                   64'h9,   4'h1, 4'hF, 0, 3'b100, 0, 0, 0, 0, 0, 3'b100, 1, 6, 0, 64'h0,                   64'h9,   4'h1, 4'hF, 0);
    vecs[7]  = mk(1, 2, 3, 64'h8,                   64'h8,   4'h3, 4'hF, 0, 3'b000, 0, 0, 0, 0, 1, 3'b100, 1, 2, 1, 64'h8,                   64'h8,   4'h3, 4'hF, 0);
    vecs[8]  = mk(1, 6, 0, 64'hA,                   64'hB,   4'h5, 4'hF, 0, 3'b001, 1, 0, 0, 0, 0, 3'b100, 1, 6, 0, 64'hA,                   64'hB,   4'h5, 4'hF, 0);
    vecs[9]  = mk(1, 6, 0, 64'hC,                   64'hD,   4'h6, 4'hF, 0, 3'b011, 0, 1, 0, 0, 0, 3'b100, 1, 6, 0, 64'hC,                   64'hD,   4'h6, 4'hF, 0);
    vecs[10] = mk(1, 6, 0, 64'hE,                   64'hF0,  4'h7, 4'hF, 2, 3'b011, 0, 0, 0, 0, 0, 3'b100, 1, 6, 0, 64'hE,                   64'hF0,  4'h7, 4'hF, 2);
    vecs[11] = mk(1, 6, 1, 64'h99,                  64'h98,  4'h5, 4'h5, 0, 3'b011, 0, 0, 1, 1, 0, 3'b100, 1, 6, 0, 64'hE,                   64'hF0,  4'h7, 4'hF, 2);
    vecs[12] = mk(1, 6, 1, 64'h99,                  64'h98,  4'h5, 4'h5, 0, 3'b011, 0, 0, 0, 1, 0, 3'b011, 0, 1, 0, 64'h0,                   64'h0,   4'hF, 4'hF, 0);
    vecs[13] = mk(1, 7, 1, 64'h11,                  64'h0,   4'hF, 4'hF, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 1, 7, 0, 64'h11,                  64'h0,   4'hF, 4'hF, 0);
    vecs[14] = mk(1, 7, 5, 64'h22,                  64'h0,   4'hF, 4'hF, 0, 3'b000, 0, 0, 0, 0, 1, 3'b011, 1, 7, 1, 64'h22,                  64'h0,   4'hF, 4'hF, 0);
    vecs[15] = mk(1, 7, 6, 64'h33,                  64'h0,   4'hF, 4'hF, 0, 3'b000, 0, 0, 0, 0, 1, 3'b011, 1, 7, 1, 64'h33,                  64'h0,   4'hF, 4'hF, 0);
    vecs[16] = mk(1, 7, 4, 64'h44,                  64'h0,   4'hF, 4'hF, 0, 3'b000, 0, 0, 0, 0, 1, 3'b011, 1, 7, 1, 64'h44,                  64'h0,   4'hF, 4'hF, 0);
    vecs[17] = mk(1, 7, 8, 64'h55,                  64'h0,   4'hF, 4'hF, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 1, 7, 0, 64'h55,                  64'h0,   4'hF, 4'hF, 0);
    vecs[18] = mk(1, 2, 0, 64'h66,                  64'h66,  4'h9, 4'hF, 0, 3'b000, 0, 0, 0, 0, 1, 3'b011, 1, 2, 1, 64'h66,                  64'h66,  4'h9, 4'hF, 0);
    vecs[19] = mk(1, 5, 0, 64'h77,                  64'h0,   4'hF, 4'hA, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 1, 5, 0, 64'h77,                  64'h0,   4'hF, 4'hA, 0);
    vecs[20] = mk(1, 3, 0, 64'h1,                   64'h2,   4'h4, 4'hF, 0, 3'b000, 0, 0, 1, 0, 0, 3'b011, 1, 5, 0, 64'h77,                  64'h0,   4'hF, 4'hA, 0);
    vecs[21] = mk(1, 2, 2, 64'h88,                  64'h88,  4'h8, 4'hF, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011, 1, 2, 0, 64'h88,                  64'h88,  4'hF, 4'hF, 0);

    // ---- hand-written sequence: async reset takes effect mid-cycle ----
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    e_valid = 1; e_icode = 4'h6; e_ifun = 0; e_valE = 64'hDEAD; e_valA = 64'hBEEF;
    e_dstE = 4'h2; alu_co = 3'b011;
    @(posedge clk); #1;
    chk("pre_rst M_valid", {63'd0, M_valid}, 64'd1);
    chk("pre_rst cc", {61'd0, cc}, 64'd3);
    $display("txn pre_rst: cc=%b M_valid=%b M_valE=%h", cc, M_valid, M_valE);
    drive_idle();
    #2 rst_n = 1'b0;   // asserted between edges
    #1;
    chk("rst cc", {61'd0, cc}, 64'd4);
    chk("rst M_valid", {63'd0, M_valid}, 64'd0);
    chk("rst M_icode", {60'd0, M_icode}, 64'd1);
    chk("rst M_cnd", {63'd0, M_cnd}, 64'd0);
    chk("rst M_valE", M_valE, 64'd0);
    chk("rst M_valA", M_valA, 64'd0);
    chk("rst M_dstE", {60'd0, M_dstE}, 64'hF);
    chk("rst M_dstM", {60'd0, M_dstM}, 64'hF);
    chk("rst M_stat", {62'd0, M_stat}, 64'd0);
    $display("txn reset: cc=%b M_valid=%b M_icode=%h M_dstE=%h", cc, M_valid, M_icode, M_dstE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven vectors through the scoreboard ----
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].s);
      #1;
      chk($sformatf("v%0d e_cnd", i), {63'd0, e_cnd}, {63'd0, vecs[i].s.x_cnd});
      sb_q.push_back(vecs[i].e);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL v%0d scoreboard: got empty queue, expected one entry", i);
      end else begin
        e = sb_q.pop_front();
        check_out(i, e);
      end
      $display("txn v%0d: icode=%h ifun=%h e_cnd=%b cc=%b M_valid=%b M_icode=%h M_cnd=%b M_valE=%h M_dstE=%h M_dstM=%h M_stat=%0d",
               i, vecs[i].s.icode, vecs[i].s.ifun, vecs[i].s.x_cnd, cc, M_valid, M_icode, M_cnd, M_valE, M_dstE, M_dstM, M_stat);
    end

    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
